exc_arbiter: RTL and testbench

// Exception/interrupt arbiter directly upstream of the CP0 register file.

---
 rtl/exc_arbiter_if.sv | 29 ++
 rtl/exc_arbiter.sv | 138 +++++++++++++
 tb/tb_exc_arbiter.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/exc_arbiter_if.sv
// Signal bundle between the commit stage / CP0 and the exception arbiter.
// The master side drives commit-stage requests; the slave side is the arbiter.
interface exc_arbiter_if;
    logic        instr_valid;
    logic [31:0] pc;
    logic        is_syscall;
    logic        is_break;
    logic        is_teq_tk;
    logic        is_eret;
    logic        intr;
    logic [31:0] status;
    logic        kill;
    logic        exception;
    logic        eret;
    logic [4:0]  cause;
    logic [31:0] exc_pc;
    logic        stall;
    logic        intr_pend;

    modport master (
        output instr_valid, pc, is_syscall, is_break, is_teq_tk, is_eret, intr, status,
        input  kill, exception, eret, cause, exc_pc, stall, intr_pend
    );

    modport slave (
        input  instr_valid, pc, is_syscall, is_break, is_teq_tk, is_eret, intr, status,
        output kill, exception, eret, cause, exc_pc, stall, intr_pend
    );
endinterface

// File: rtl/exc_arbiter.sv
// Exception/interrupt arbiter feeding CP0: masks, prioritises and pulses one event, then stalls fetch.
// Define INTR_SYNC_EN to pass intr through a 2-flop synchroniser before edge detection.
module exc_arbiter #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter logic [4:0]  INTR_CAUSE   = 5'b00000
) (
    input  logic          clk,
    input  logic          rst,
    exc_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, PULSE, FLUSH} state_t;

    localparam logic [4:0] CAUSE_SYS  = 5'b01000;
    localparam logic [4:0] CAUSE_BRK  = 5'b01001;
    localparam logic [4:0] CAUSE_TEQ  = 5'b01101;
    localparam logic [3:0] CNT_LOAD   = 4'(FLUSH_CYCLES - 1);

    state_t      state, state_nxt;
    logic [3:0]  cnt;
    logic        ev_is_eret;
    logic [4:0]  cause_q;
    logic [31:0] exc_pc_q;
    logic        intr_pend_q;
    logic        intr_rise;

    logic        ie, accept, q_sys, q_brk, q_teq, trap_any;
    logic        take_eret, take_trap, take_intr, take_any;
    logic [4:0]  ev_cause;
    logic        unused_status;

    assign unused_status = ^bus.status[31:5];

    // Interrupt edge detection, optionally behind a synchroniser.
`ifdef INTR_SYNC_EN
    logic intr_meta, intr_sync, intr_dly;

    always_ff @(posedge clk) begin
        if (!rst) begin
            intr_meta <= 1'b0;
            intr_sync <= 1'b0;
            intr_dly  <= 1'b0;
        end else begin
            intr_meta <= bus.intr;
            intr_sync <= intr_meta;
            intr_dly  <= intr_sync;
        end
    end

    assign intr_rise = intr_sync & ~intr_dly;
`else
    logic intr_dly;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) intr_dly <= 1'b0;
        else      intr_dly <= bus.intr;
    end

    assign intr_rise = bus.intr & ~intr_dly;
`endif

    // Request qualification and priority: eret > syscall > break > teq > interrupt.
    assign ie        = bus.status[0];
    assign accept    = (state == IDLE) && bus.instr_valid;
    assign q_sys     = bus.is_syscall & ie & bus.status[1];
    assign q_brk     = bus.is_break   & ie & bus.status[2];
    assign q_teq     = bus.is_teq_tk  & ie & bus.status[3];
    assign trap_any  = q_sys | q_brk | q_teq;
    assign take_eret = accept & bus.is_eret;
    assign take_trap = accept & ~bus.is_eret & trap_any;
    assign take_intr = accept & ~bus.is_eret & ~trap_any & intr_pend_q & ie & bus.status[4];
    assign take_any  = take_eret | take_trap | take_intr;

    always_comb begin
        // NOTE: default first so no path leaves ev_cause unassigned (no latch).
        ev_cause = INTR_CAUSE;
        if (q_sys)      ev_cause = CAUSE_SYS;
        else if (q_brk) ev_cause = CAUSE_BRK;
        else if (q_teq) ev_cause = CAUSE_TEQ;
    end

    // FSM: state register.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and active-low; it is only seen at a clock edge.
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // FSM: next state.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (take_any) state_nxt = PULSE;
            PULSE:   state_nxt = FLUSH;
            FLUSH:   if (cnt == 4'd0) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs. kill is taken straight from the acceptance logic so writeback is blocked in-cycle.
    always_comb begin
        bus.kill      = rst & (take_trap | take_intr);
        bus.exception = (state == PULSE) & ~ev_is_eret;
        bus.eret      = (state == PULSE) &  ev_is_eret;
        bus.stall     = (state != IDLE);
    end

    // Flush counter, captured event and pending interrupt latch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt         <= 4'd0;
            ev_is_eret  <= 1'b0;
            cause_q     <= 5'd0;
            exc_pc_q    <= 32'd0;
            intr_pend_q <= 1'b0;
        end else begin
            if (state == PULSE)
                cnt <= CNT_LOAD;
            else if (state == FLUSH && cnt != 4'd0)
                cnt <= cnt - 4'd1;

            if (take_any) begin
                ev_is_eret <= take_eret;
                exc_pc_q   <= bus.pc;
                if (!take_eret) cause_q <= ev_cause;
            end

            // A new edge in the same cycle as acceptance keeps the latch set.
            intr_pend_q <= intr_rise | (intr_pend_q & ~take_intr);
        end
    end

    assign bus.cause     = cause_q;
    assign bus.exc_pc    = exc_pc_q;
    assign bus.intr_pend = intr_pend_q;

endmodule

// File: tb/tb_exc_arbiter.sv
// Scoreboarded bench for exc_arbiter: directed stimulus queues expected CP0 pulses,
// a negedge monitor pops and compares them whenever exception or eret is seen.
module tb_exc_arbiter;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    exc_arbiter_if bus();

    exc_arbiter #(
        .FLUSH_CYCLES (2),
        .INTR_CAUSE   (5'b00000)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct packed {
        logic        exc;
        logic        eret;
        logic [4:0]  cause;
        logic [31:0] pc;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every CP0 pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (rst === 1'b1 && (bus.exception === 1'b1 || bus.eret === 1'b1)) begin
            if (sb.size() == 0) begin
                n_total++;
                $display("FAIL unexpected_pulse: got exception=%0b eret=%0b cause=0x%0h pc=0x%0h with nothing expected",
                         bus.exception, bus.eret, bus.cause, bus.exc_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("pulse_exception", 32'(bus.exception), 32'(e.exc));
                check("pulse_eret",      32'(bus.eret),      32'(e.eret));
                check("pulse_cause",     32'(bus.cause),     32'(e.cause));
                check("pulse_exc_pc",    bus.exc_pc,         e.pc);
            end
        end
    end

    task automatic clear_instr();
        bus.instr_valid = 1'b0;
        bus.pc          = 32'd0;
        bus.is_syscall  = 1'b0;
        bus.is_break    = 1'b0;
        bus.is_teq_tk   = 1'b0;
        bus.is_eret     = 1'b0;
    endtask

    task automatic drive(input logic [31:0] p, input logic sys, input logic brk,
                         input logic teq, input logic er);
        bus.instr_valid = 1'b1;
        bus.pc          = p;
        bus.is_syscall  = sys;
        bus.is_break    = brk;
        bus.is_teq_tk   = teq;
        bus.is_eret     = er;
    endtask

    task automatic expect_pulse(input logic exc, input logic er, input logic [4:0] c,
                                input logic [31:0] p);
        exp_t e;
        e = {exc, er, c, p};
        sb.push_back(e);
    endtask

    // Present one instruction for a single IDLE cycle and check kill; returns at T+1 (+1ns).
    task automatic take(input string name, input logic [31:0] p, input logic sys,
                        input logic brk, input logic teq, input logic er, input logic kill_exp);
        @(posedge clk); #1;
        drive(p, sys, brk, teq, er);
        @(negedge clk);
        check({name, "_kill"}, 32'(bus.kill), 32'(kill_exp));
        @(posedge clk); #1;
        clear_instr();
    endtask

    // Count stalled cycles until stall drops (bounded), then clear inputs at that negedge.
    task automatic wait_idle(input int exp_stall, input string name);
        int  n    = 0;
        bit  done = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (bus.stall === 1'b1) n++;
            else done = 1'b1;
        end
        check(name, 32'(n), 32'(exp_stall));
        clear_instr();
    endtask

    task automatic raise_intr();
        @(posedge clk); #1;
        bus.intr = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst        = 1'b0;
        bus.intr   = 1'b0;
        bus.status = 32'd0;
        clear_instr();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_kill",      32'(bus.kill),      32'd0);
        check("rst_exception", 32'(bus.exception), 32'd0);
        check("rst_eret",      32'(bus.eret),      32'd0);
        check("rst_stall",     32'(bus.stall),     32'd0);
        check("rst_intr_pend", 32'(bus.intr_pend), 32'd0);
        check("rst_cause",     32'(bus.cause),     32'd0);
        check("rst_exc_pc",    bus.exc_pc,         32'd0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Enabled syscall: kill at T, pulse at T+1, 3 stall cycles, cause/pc hold afterwards.
        bus.status = 32'h3;
        expect_pulse(1'b1, 1'b0, 5'b01000, 32'h0040_0010);
        take("t1_sys", 32'h0040_0010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle(3, "t1_stall_len");
        check("t1_cause_hold",  32'(bus.cause), 32'h08);
        check("t1_exc_pc_hold", bus.exc_pc,     32'h0040_0010);

        // A request arriving while busy is ignored and kill stays low.
        bus.status = 32'h7;
        expect_pulse(1'b1, 1'b0, 5'b01000, 32'h0040_0020);
        take("t1b_sys", 32'h0040_0020, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        drive(32'h0040_0024, 1'b0, 1'b1, 1'b0, 1'b0);
        @(negedge clk);
        check("t1b_kill_busy", 32'(bus.kill), 32'd0);
        wait_idle(2, "t1b_stall_rest");

        // Masked syscall commits normally.
        bus.status = 32'h1;
        take("t2_masked", 32'h0040_0030, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t2_stall",     32'(bus.stall),     32'd0);
        check("t2_exception", 32'(bus.exception), 32'd0);

        // Masked syscall does not hide an enabled break.
        bus.status = 32'h5;
        expect_pulse(1'b1, 1'b0, 5'b01001, 32'h0040_0034);
        take("t2b_brk", 32'h0040_0034, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_idle(3, "t2b_stall_len");

        // All traps enabled: syscall beats break and teq.
        bus.status = 32'hF;
        expect_pulse(1'b1, 1'b0, 5'b01000, 32'h0040_0038);
        take("t2c_prio", 32'h0040_0038, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        wait_idle(3, "t2c_stall_len");

        // TEQ alone.
        bus.status = 32'h9;
        expect_pulse(1'b1, 1'b0, 5'b01101, 32'h0040_003C);
        take("t2d_teq", 32'h0040_003C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        wait_idle(3, "t2d_stall_len");

        // Break coinciding with a pending interrupt: break wins, interrupt follows.
        bus.status = 32'h1F;
        raise_intr();
        check("t3_pend_set", 32'(bus.intr_pend), 32'd1);
        expect_pulse(1'b1, 1'b0, 5'b01001, 32'h0040_0040);
        take("t3_brk", 32'h0040_0040, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        wait_idle(3, "t3_stall_len");
        check("t3_pend_held", 32'(bus.intr_pend), 32'd1);
        expect_pulse(1'b1, 1'b0, 5'b00000, 32'h0040_0050);
        take("t3_intr", 32'h0040_0050, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle(3, "t3_intr_stall_len");
        check("t3_pend_clear", 32'(bus.intr_pend), 32'd0);
        bus.intr = 1'b0;

        // ERET beats a taken TEQ: eret pulse, no kill, cause keeps its previous value.
        bus.status = 32'h9;
        expect_pulse(1'b0, 1'b1, 5'b00000, 32'h0040_0060);
        take("t4_eret", 32'h0040_0060, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        wait_idle(3, "t4_stall_len");

        // Interrupt pulse while IE=0 stays pending until unmasked.
        bus.status = 32'h0;
        @(posedge clk); #1;
        bus.intr = 1'b1;
        @(posedge clk); #1;
        bus.intr = 1'b0;
        @(negedge clk);
        check("t5_pend_set", 32'(bus.intr_pend), 32'd1);
        take("t5_masked", 32'h0040_0070, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("t5_pend_masked", 32'(bus.intr_pend), 32'd1);
        check("t5_no_stall",    32'(bus.stall),     32'd0);
        bus.status = 32'h11;
        expect_pulse(1'b1, 1'b0, 5'b00000, 32'h0040_0080);
        take("t5_intr", 32'h0040_0080, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle(3, "t5_stall_len");
        check("t5_pend_clear", 32'(bus.intr_pend), 32'd0);

        // Reset in FLUSH clears everything; the next instruction starts a fresh sequence.
        bus.status = 32'h3;
        raise_intr();
        check("t6_pend_set", 32'(bus.intr_pend), 32'd1);
        expect_pulse(1'b1, 1'b0, 5'b01000, 32'h0040_0090);
        take("t6_sys", 32'h0040_0090, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        @(posedge clk); #1;
        rst      = 1'b0;
        bus.intr = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("t6_rst_stall",     32'(bus.stall),     32'd0);
        check("t6_rst_exception", 32'(bus.exception), 32'd0);
        check("t6_rst_eret",      32'(bus.eret),      32'd0);
        check("t6_rst_intr_pend", 32'(bus.intr_pend), 32'd0);
        check("t6_rst_cause",     32'(bus.cause),     32'd0);
        check("t6_rst_exc_pc",    bus.exc_pc,         32'd0);
        rst = 1'b1;
        expect_pulse(1'b1, 1'b0, 5'b01000, 32'h0040_00A0);
        take("t6_fresh", 32'h0040_00A0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        wait_idle(3, "t6_fresh_stall_len");

        repeat (3) @(negedge clk);
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
